// File: rtl/dica_ckpt_engine.sv
// Dirty-block tracker for intermittent checkpointing of the openMSP430 DMEM: marks written
// blocks, prunes dead stack frames, raises a checkpoint request and streams dirty blocks out.
module dica_ckpt_engine #(
    parameter logic [15:0] DMEM_BASE = 16'h0200,
    parameter int          DMEM_SIZE = 2048,
    parameter int          BLK_SIZE  = 64,
    parameter logic [15:0] STK_LO    = 16'h0A00,
    parameter logic [31:0] V_MIN     = 32'h100,
    parameter int          LAMBDA_W  = 31,
    localparam int         NBLK      = DMEM_SIZE / BLK_SIZE,
    localparam int         CNT_W     = $clog2(NBLK + 1),
    localparam int         IDX_W     = (NBLK > 1) ? $clog2(NBLK) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         data_addr,
    input  logic                data_wr,
    input  logic [15:0]         sp,
    input  logic [LAMBDA_W-1:0] lambda,
    input  logic [31:0]         v_supply,
    input  logic                ckpt_start,
    input  logic                blk_ready,
    output logic                irq_chkpnt,
    output logic                blk_valid,
    output logic [IDX_W-1:0]    blk_idx,
    output logic [15:0]         blk_addr,
    output logic                ckpt_done,
    output logic [CNT_W-1:0]    dirty_cnt,
    output logic [31:0]         v_thresh,
    output logic [NBLK-1:0]     dtable
);

    localparam int               BLK_SH   = $clog2(BLK_SIZE);
    localparam logic [31:0]      BASE32   = {16'b0, DMEM_BASE};
    localparam logic [31:0]      LAST32   = BASE32 + 32'(DMEM_SIZE) - 32'd1;
    localparam logic [31:0]      STK32    = {16'b0, STK_LO};
    localparam logic [31:0]      STK_BLK  = (STK32 >= BASE32) ? ((STK32 - BASE32) >> BLK_SH) : 32'd0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SCAN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [15:0]      sp_prev;

    logic [31:0]      addr32;
    logic [31:0]      sp32;
    logic [31:0]      sp_blk;
    logic             wr_hit;
    logic             sp_in;
    logic             prune_en;
    logic             cur_dirty;
    logic             accept;
    logic             scan_step;
    logic             ptr_last;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] ptr_inc;
    logic [NBLK-1:0]  wr_mask;
    logic [NBLK-1:0]  prune_mask;
    logic [NBLK-1:0]  acc_mask;
    logic [NBLK-1:0]  dtable_next;
    logic [47:0]      thresh_wide;

    assign addr32 = {16'b0, data_addr};
    assign sp32   = {16'b0, sp};
    assign wr_hit = data_wr && (addr32 >= BASE32) && (addr32 <= LAST32);
    assign wr_idx = IDX_W'((addr32 - BASE32) >> BLK_SH);
    assign sp_blk = (sp32 - BASE32) >> BLK_SH;

    // Pruning only makes sense while the CPU runs freely; a rising SP frees the frames below it.
    assign sp_in    = (sp != 16'd0) && (sp32 >= BASE32) && (sp32 <= LAST32);
    assign prune_en = (state == IDLE) && sp_in && (sp > sp_prev);

    assign cur_dirty = dtable[ptr];
    assign accept    = (state == SCAN) && cur_dirty && blk_ready;
    assign scan_step = (state == SCAN) && (!cur_dirty || blk_ready);
    assign ptr_last  = (ptr == LAST_IDX);
    assign ptr_inc   = ptr + 1'b1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_mask    = '0;
        acc_mask   = '0;
        prune_mask = '0;
        if (wr_hit) wr_mask[wr_idx] = 1'b1;
        if (accept) acc_mask[ptr]   = 1'b1;
        for (int i = 0; i < NBLK; i++) begin
            prune_mask[i] = prune_en && (32'(i) >= STK_BLK) && (32'(i) < sp_blk);
        end
        // A write in the same cycle as a prune or an accept re-dirties the block.
        dtable_next = (dtable & ~prune_mask & ~acc_mask) | wr_mask;
    end

    assign thresh_wide = 48'(dirty_cnt) * 48'(lambda) + 48'(V_MIN);

    assign blk_idx  = ptr;
    assign blk_addr = DMEM_BASE + (16'(ptr) << BLK_SH);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            sp_prev    <= 16'd0;
            dtable     <= '0;
            dirty_cnt  <= '0;
            v_thresh   <= V_MIN;
            irq_chkpnt <= 1'b0;
            blk_valid  <= 1'b0;
            ckpt_done  <= 1'b0;
        end else begin
            dtable    <= dtable_next;
            dirty_cnt <= CNT_W'($countones(dtable_next));
            v_thresh  <= (|thresh_wide[47:32]) ? 32'hFFFF_FFFF : thresh_wide[31:0];
            if (sp != 16'd0) sp_prev <= sp;
            ckpt_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (v_supply <= v_thresh) begin
                        state      <= ARMED;
                        irq_chkpnt <= 1'b1;
                    end
                end
                ARMED: begin
                    if (ckpt_start) begin
                        state      <= SCAN;
                        irq_chkpnt <= 1'b0;
                        ptr        <= '0;
                        blk_valid  <= dtable_next[0];
                    end
                end
                SCAN: begin
                    // Valid is looked ahead from the next table so it only falls on an accept.
                    if (scan_step) begin
                        if (ptr_last) begin
                            state     <= DONE;
                            blk_valid <= 1'b0;
                            ckpt_done <= 1'b1;
                        end else begin
                            ptr       <= ptr_inc;
                            blk_valid <= dtable_next[ptr_inc];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dica_ckpt_engine.sv
// Bench for dica_ckpt_engine: directed scenarios then random traffic against a bit-array model.
// A 4 KiB DMEM is used so the stack region at 0x0A00 lies inside tracked memory.
module tb_dica_ckpt_engine;

    localparam logic [15:0] BASE  = 16'h0200;
    localparam int          DSIZE = 4096;
    localparam int          BSIZE = 64;
    localparam logic [15:0] STK   = 16'h0A00;
    localparam logic [31:0] VMIN  = 32'h100;
    localparam int          LW    = 31;
    localparam int          NB    = DSIZE / BSIZE;
    localparam int          CW    = $clog2(NB + 1);
    localparam int          IW    = $clog2(NB);

    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_WALK = 2, PH_DONE = 3;

    logic          clk;
    logic          reset_n;
    logic [15:0]   data_addr;
    logic          data_wr;
    logic [15:0]   sp;
    logic [LW-1:0] lambda;
    logic [31:0]   v_supply;
    logic          ckpt_start;
    logic          blk_ready;
    logic          irq_chkpnt;
    logic          blk_valid;
    logic [IW-1:0] blk_idx;
    logic [15:0]   blk_addr;
    logic          ckpt_done;
    logic [CW-1:0] dirty_cnt;
    logic [31:0]   v_thresh;
    logic [NB-1:0] dtable;

    dica_ckpt_engine #(
        .DMEM_BASE(BASE), .DMEM_SIZE(DSIZE), .BLK_SIZE(BSIZE),
        .STK_LO(STK), .V_MIN(VMIN), .LAMBDA_W(LW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_addr(data_addr), .data_wr(data_wr),
        .sp(sp), .lambda(lambda), .v_supply(v_supply), .ckpt_start(ckpt_start),
        .blk_ready(blk_ready), .irq_chkpnt(irq_chkpnt), .blk_valid(blk_valid),
        .blk_idx(blk_idx), .blk_addr(blk_addr), .ckpt_done(ckpt_done),
        .dirty_cnt(dirty_cnt), .v_thresh(v_thresh), .dtable(dtable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: one flag per block, the checkpoint phase and the walk position.
    bit              md[NB];
    int              mcnt;
    longint unsigned mthr;
    int unsigned     msp_prev;
    int              mph;
    int              mptr;

    function automatic int blk_of(input int unsigned a);
        return int'((a - BASE) / BSIZE);
    endfunction

    function automatic bit in_dmem(input int unsigned a);
        return (a >= BASE) && (a < BASE + DSIZE);
    endfunction

    function automatic logic [NB-1:0] model_table();
        logic [NB-1:0] t;
        for (int i = 0; i < NB; i++) t[i] = md[i];
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) md[i] = 1'b0;
        mcnt = 0; mthr = VMIN; msp_prev = 0; mph = PH_IDLE; mptr = 0;
    endtask

    task automatic model_step();
        bit              cur;
        int              cnt_old;
        longint unsigned thr_old;
        if (!reset_n) begin
            model_reset();
            return;
        end
        cur     = (mph == PH_WALK) && md[mptr];
        cnt_old = mcnt;
        thr_old = mthr;
        if (mph == PH_IDLE && sp != 0 && in_dmem(sp) && sp > msp_prev)
            for (int i = blk_of(STK); i < blk_of(sp); i++) md[i] = 1'b0;
        if (cur && blk_ready) md[mptr] = 1'b0;
        if (data_wr && in_dmem(data_addr)) md[blk_of(data_addr)] = 1'b1;
        mcnt = 0;
        for (int i = 0; i < NB; i++) mcnt += md[i];
        mthr = longint'(VMIN) + longint'(cnt_old) * longint'(lambda);
        if (mthr > 64'hFFFF_FFFF) mthr = 64'hFFFF_FFFF;
        case (mph)
            PH_IDLE:  if (longint'(v_supply) <= thr_old) mph = PH_ARMED;
            PH_ARMED: if (ckpt_start) begin mph = PH_WALK; mptr = 0; end
            PH_WALK:  if (!cur || blk_ready) begin
                          if (mptr == NB - 1) mph = PH_DONE;
                          else mptr++;
                      end
            default:  mph = PH_IDLE;
        endcase
        if (sp != 0) msp_prev = sp;
    endtask

    task automatic tick();
        bit exp_valid;
        model_step();
        @(posedge clk);
        #1;
        exp_valid = (mph == PH_WALK) && md[mptr];
        check("dtable", dtable, model_table());
        check("dirty_cnt", dirty_cnt, mcnt);
        check("v_thresh", v_thresh, mthr);
        check("irq_chkpnt", irq_chkpnt, mph == PH_ARMED);
        check("blk_valid", blk_valid, exp_valid);
        check("ckpt_done", ckpt_done, mph == PH_DONE);
        if (exp_valid) begin
            check("blk_idx", blk_idx, mptr);
            check("blk_addr", blk_addr, 16'(BASE + mptr * BSIZE));
        end
    endtask

    task automatic wr(input logic [15:0] a);
        data_wr = 1'b1; data_addr = a;
        tick();
        data_wr = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; data_addr = '0; data_wr = 1'b0; sp = '0; lambda = LW'(5);
        v_supply = 32'hFFFF_FFFF; ckpt_start = 1'b0; blk_ready = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_dtable", dtable, 0);
        check("rst_v_thresh", v_thresh, VMIN);
        reset_n = 1'b1;

        // Write tracking: two writes into block 0, one into block 1.
        wr(16'h0200); wr(16'h0210); wr(16'h0240);
        check("wr_dtable", dtable[1:0], 2'b11);
        check("wr_cnt", dirty_cnt, 2);
        tick();
        check("wr_thresh", v_thresh, VMIN + 2 * 5);

        // Stack pruning of blocks 32 and 33, then a prune that loses to a same-cycle write.
        wr(16'h0A00); wr(16'h0A40);
        sp = 16'h0A3E; tick();
        sp = 16'h0A80; tick();
        check("prune_bits", dtable[33:32], 2'b00);
        check("prune_keep", dtable[1:0], 2'b11);
        check("prune_cnt", dirty_cnt, 2);
        wr(16'h0A00); wr(16'h0A40);
        sp = 16'h0AC0; data_wr = 1'b1; data_addr = 16'h0A50; tick(); data_wr = 1'b0;
        check("prune_wr_wins", dtable[33:32], 2'b10);
        check("prune_wr_cnt", dirty_cnt, 3);
        sp = 16'h0000;

        // Walk over dirty blocks 3 and 7 with a stalled consumer.
        lambda = LW'(16);
        do_reset();
        wr(16'h02C0); wr(16'h03C0);
        tick(); tick();
        v_supply = 32'h110; tick();
        check("armed_irq", irq_chkpnt, 1);
        v_supply = 32'hFFFF_FFFF;
        ckpt_start = 1'b1; tick(); ckpt_start = 1'b0;
        check("start_irq_low", irq_chkpnt, 0);
        for (int i = 0; i < 20 && !(mph == PH_WALK && md[mptr]); i++) tick();
        check("offer_idx3", blk_idx, 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", blk_valid, 1);
            check("hold_idx", blk_idx, 3);
            check("hold_addr", blk_addr, 16'h02C0);
        end
        blk_ready = 1'b1;
        tick();
        check("acc3_cleared", dtable[3], 0);
        for (int i = 0; i < 20 && !(mph == PH_WALK && mptr == 7); i++) tick();
        check("offer_idx7", blk_idx, 7);
        data_wr = 1'b1; data_addr = 16'h03C0; tick(); data_wr = 1'b0;
        check("acc7_rewrite", dtable[7], 1);
        check("acc7_cnt", dirty_cnt, 1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = ckpt_done;
        end
        check("walk_done", seen, 1);
        blk_ready = 1'b0;

        // Reset in the middle of a walk.
        wr(16'h0300);
        v_supply = 32'h0; tick(); tick();
        ckpt_start = 1'b1; tick(); ckpt_start = 1'b0;
        v_supply = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) tick();
        reset_n = 1'b0; tick();
        check("mid_rst_dtable", dtable, 0);
        check("mid_rst_thresh", v_thresh, VMIN);
        check("mid_rst_irq", irq_chkpnt, 0);
        check("mid_rst_done", ckpt_done, 0);
        reset_n = 1'b1;

        // Random traffic, including range edges, SP jumps, saturating lambda and resets.
        for (int n = 0; n < 3000; n++) begin
            data_wr = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       data_addr = 16'h01FF;
                1:       data_addr = 16'h0200;
                2:       data_addr = 16'h11FF;
                3:       data_addr = 16'h1200;
                default: data_addr = 16'($urandom_range(16'h0100, 16'h1300));
            endcase
            if ($urandom_range(0, 19) == 0) sp = 16'($urandom_range(0, 16'h1400));
            if ($urandom_range(0, 49) == 0)
                lambda = ($urandom_range(0, 1) == 0) ? LW'($urandom) : LW'($urandom_range(0, 64));
            if ($urandom_range(0, 9) == 0) v_supply = $urandom;
            else v_supply = 32'(mthr) + 32'($urandom_range(0, 8)) - 32'd4;
            ckpt_start = ($urandom_range(0, 3) == 0);
            blk_ready  = ($urandom_range(0, 1) == 1);
            reset_n    = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
